// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding select
// codes, branch-squash FSM state encoding and register index width.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SH1  = 2'b01,
    SH2  = 2'b10
  } br_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One operand's forwarding select. The memory stage holds the younger
// result, so it wins over writeback when both name the same register.
// Register x0 is hardwired to zero and is never a forwarding source.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_E,
  input  logic [REG_W-1:0] rd_M,
  input  logic             regwrt_M,
  input  logic [REG_W-1:0] rd_W,
  input  logic             regwrt_W,
  output logic [1:0]       frwd
);

  // Priority select: memory stage, then writeback, else register file.
  always_comb begin
    frwd = FWD_RF;
    if (regwrt_M && (rd_M == rs_E) && (rd_M != '0)) begin
      frwd = FWD_MEM;
    end else if (regwrt_W && (rd_W == rs_E) && (rd_W != '0)) begin
      frwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall and the
// two-slot wrong-path squash after a taken branch.
// Optional feature macro: HAZARD_PERF_CNT_EN builds saturating stall/flush
// event counters; without it stall_cnt/flush_cnt read as zero.
//
// state | meaning
// IDLE  | no squash in progress, taken branches are honoured
// SH1   | first wrong-path slot after a taken branch, PC_Exmux ignored
// SH2   | second wrong-path slot, PC_Exmux ignored
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rs1_E,
  input  logic [REG_W-1:0] rs2_E,
  input  logic [REG_W-1:0] RD_E,
  input  logic             resultctrl_E,
  input  logic [REG_W-1:0] RD_M,
  input  logic             regwrt_M,
  input  logic [REG_W-1:0] RD_W,
  input  logic             regwrt_W,
  input  logic             PC_Exmux,
  output logic [1:0]       FrwdA_E,
  output logic [1:0]       FrwdB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             shadow,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  br_state_t  r_state;
  br_state_t  w_state_nxt;
  logic [1:0] w_frwd_a;
  logic [1:0] w_frwd_b;
  logic       w_lw_stall;
  logic       w_br_eff;

  hazard_fwd_sel u_fwd_a (
    .rs_E     (rs1_E),
    .rd_M     (RD_M),
    .regwrt_M (regwrt_M),
    .rd_W     (RD_W),
    .regwrt_W (regwrt_W),
    .frwd     (w_frwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_E     (rs2_E),
    .rd_M     (RD_M),
    .regwrt_M (regwrt_M),
    .rd_W     (RD_W),
    .regwrt_W (regwrt_W),
    .frwd     (w_frwd_b)
  );

  assign w_lw_stall = resultctrl_E && (RD_E != '0) &&
                      ((RD_E == rs1_D) || (RD_E == rs2_D));
  // A branch is honoured only outside the squash window; inside it the
  // branch instruction itself is wrong-path.
  assign w_br_eff   = rst && PC_Exmux && (r_state == IDLE);

  // Branch-squash state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a taken branch opens a fixed two-slot squash window.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_br_eff ? SH1 : IDLE;
      SH1:     w_state_nxt = SH2;
      SH2:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: all forced low during reset; a taken branch overrides the
  // load-use stall because the dependent consumer is being squashed.
  always_comb begin
    FrwdA_E = FWD_RF;
    FrwdB_E = FWD_RF;
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    shadow  = 1'b0;
    if (rst) begin
      FrwdA_E = w_frwd_a;
      FrwdB_E = w_frwd_b;
      stall_F = w_lw_stall && !w_br_eff;
      stall_D = w_lw_stall && !w_br_eff;
      flush_D = w_br_eff;
      flush_E = w_br_eff || w_lw_stall;
      shadow  = (r_state != IDLE);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters for stalled fetch cycles and honoured branches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_F && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_br_eff && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, RD_E, RD_M, RD_W;
  logic        resultctrl_E, regwrt_M, regwrt_W, PC_Exmux;
  logic [1:0]  FrwdA_E, FrwdB_E;
  logic        stall_F, stall_D, flush_D, flush_E, shadow;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: number of squash slots still to run, and event counts.
  int          m_left = 0;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_D        (rs1_D),
    .rs2_D        (rs2_D),
    .rs1_E        (rs1_E),
    .rs2_E        (rs2_E),
    .RD_E         (RD_E),
    .resultctrl_E (resultctrl_E),
    .RD_M         (RD_M),
    .regwrt_M     (regwrt_M),
    .RD_W         (RD_W),
    .regwrt_W     (regwrt_W),
    .PC_Exmux     (PC_Exmux),
    .FrwdA_E      (FrwdA_E),
    .FrwdB_E      (FrwdB_E),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .shadow       (shadow),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (regwrt_M && RD_M == rs && RD_M != 0) return 2'b10;
    if (regwrt_W && RD_W == rs && RD_W != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lw();
    return resultctrl_E && RD_E != 0 && (RD_E == rs1_D || RD_E == rs2_D);
  endfunction

  function automatic logic exp_br();
    return rst && PC_Exmux && (m_left == 0);
  endfunction

  task automatic model_check(input string tag);
    logic on, lw, br;
    on = rst;
    lw = exp_lw();
    br = exp_br();
    chk({tag, ".FrwdA_E"}, {30'd0, FrwdA_E}, on ? {30'd0, exp_fwd(rs1_E)} : 32'd0);
    chk({tag, ".FrwdB_E"}, {30'd0, FrwdB_E}, on ? {30'd0, exp_fwd(rs2_E)} : 32'd0);
    chk({tag, ".stall_F"}, {31'd0, stall_F}, {31'd0, on && lw && !br});
    chk({tag, ".stall_D"}, {31'd0, stall_D}, {31'd0, on && lw && !br});
    chk({tag, ".flush_D"}, {31'd0, flush_D}, {31'd0, br});
    chk({tag, ".flush_E"}, {31'd0, flush_E}, {31'd0, on && (br || lw)});
    chk({tag, ".shadow"},  {31'd0, shadow},  {31'd0, on && (m_left != 0)});
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall_cnt);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush_cnt);
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    logic br, st;
    br = exp_br();
    st = rst && exp_lw() && !br;
    @(posedge clk);
    if (rst) begin
      if (br) m_left = 2;
      else if (m_left > 0) m_left = m_left - 1;
`ifdef HAZARD_PERF_CNT_EN
      if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      if (br && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
`endif
    end
    #1;
  endtask

  task automatic model_reset();
    m_left = 0;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic clear_in();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    resultctrl_E = 0; regwrt_M = 0; regwrt_W = 0; PC_Exmux = 0;
  endtask

  task automatic rand_in();
    rs1_D = 5'($urandom_range(0, 3));
    rs2_D = 5'($urandom_range(0, 3));
    rs1_E = 5'($urandom_range(0, 3));
    rs2_E = 5'($urandom_range(0, 3));
    RD_E  = 5'($urandom_range(0, 3));
    RD_M  = 5'($urandom_range(0, 3));
    RD_W  = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) RD_M = 5'($urandom_range(0, 31));
    resultctrl_E = 1'($urandom_range(0, 1));
    regwrt_M     = 1'($urandom_range(0, 1));
    regwrt_W     = 1'($urandom_range(0, 1));
    PC_Exmux     = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    // Reset with inputs that would otherwise stall, flush and forward.
    resultctrl_E = 1; RD_E = 7; rs2_D = 7; PC_Exmux = 1;
    regwrt_M = 1; RD_M = 4; rs1_E = 4;
    #2;
    model_check("reset");
    chk("reset.flush_E_lit", {31'd0, flush_E}, 32'd0);
    chk("reset.FrwdA_lit", {30'd0, FrwdA_E}, 32'd0);
    #6 rst = 1'b1;
    clear_in();

    // Memory beats writeback, then writeback alone.
    RD_M = 5; regwrt_M = 1; RD_W = 5; regwrt_W = 1; rs1_E = 5; rs2_E = 3;
    #1;
    chk("fwd_mem.FrwdA_lit", {30'd0, FrwdA_E}, 32'd2);
    chk("fwd_mem.FrwdB_lit", {30'd0, FrwdB_E}, 32'd0);
    model_check("fwd_mem");
    tick();
    regwrt_M = 0;
    #1;
    chk("fwd_wb.FrwdA_lit", {30'd0, FrwdA_E}, 32'd1);
    model_check("fwd_wb");
    tick();

    // x0 never forwards.
    clear_in();
    RD_M = 0; regwrt_M = 1; RD_W = 0; regwrt_W = 1; rs1_E = 0;
    #1;
    chk("fwd_x0.FrwdA_lit", {30'd0, FrwdA_E}, 32'd0);
    model_check("fwd_x0");
    tick();

    // Load-use stall for two cycles.
    clear_in();
    resultctrl_E = 1; RD_E = 7; rs2_D = 7;
    #1;
    chk("lw.stall_F_lit", {31'd0, stall_F}, 32'd1);
    chk("lw.stall_D_lit", {31'd0, stall_D}, 32'd1);
    chk("lw.flush_E_lit", {31'd0, flush_E}, 32'd1);
    chk("lw.flush_D_lit", {31'd0, flush_D}, 32'd0);
    model_check("lw0");
    tick();
    #1 model_check("lw1");
    tick();
    #1 model_check("lw2");

    // Taken branch held high for three cycles: only the first is honoured.
    clear_in();
    PC_Exmux = 1;
    #1;
    chk("br.N.flush_D_lit", {31'd0, flush_D}, 32'd1);
    chk("br.N.shadow_lit", {31'd0, shadow}, 32'd0);
    model_check("brN");
    tick();
    #1;
    chk("br.N1.flush_D_lit", {31'd0, flush_D}, 32'd0);
    chk("br.N1.shadow_lit", {31'd0, shadow}, 32'd1);
    model_check("brN1");
    tick();
    #1;
    chk("br.N2.flush_D_lit", {31'd0, flush_D}, 32'd0);
    chk("br.N2.shadow_lit", {31'd0, shadow}, 32'd1);
    model_check("brN2");
    tick();
    PC_Exmux = 0;
    #1;
    chk("br.N3.shadow_lit", {31'd0, shadow}, 32'd0);
    model_check("brN3");
    tick();

    // Branch with load-use in the same cycle: branch wins.
    resultctrl_E = 1; RD_E = 9; rs1_D = 9; PC_Exmux = 1;
    #1;
    chk("brlw.flush_D_lit", {31'd0, flush_D}, 32'd1);
    chk("brlw.flush_E_lit", {31'd0, flush_E}, 32'd1);
    chk("brlw.stall_F_lit", {31'd0, stall_F}, 32'd0);
    chk("brlw.stall_D_lit", {31'd0, stall_D}, 32'd0);
    model_check("brlw");
    tick();

    // Now in SH1: load in the shadow still stalls; then reset mid-window.
    #1;
    chk("sh1.shadow_lit", {31'd0, shadow}, 32'd1);
    chk("sh1.stall_F_lit", {31'd0, stall_F}, 32'd1);
    model_check("sh1");
    #1 rst = 1'b0;
    #1;
    chk("rst_sh1.shadow_lit", {31'd0, shadow}, 32'd0);
    chk("rst_sh1.flush_E_lit", {31'd0, flush_E}, 32'd0);
    model_reset();
    model_check("rst_sh1");
    #2 rst = 1'b1;
    #1;
    chk("post_rst.flush_D_lit", {31'd0, flush_D}, 32'd1);
    model_check("post_rst");
    tick();

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      #1;
      model_check("rand");
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b0;
        #1;
        model_reset();
        model_check("rand_rst");
        #1 rst = 1'b1;
        #1 model_check("rand_rel");
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
